// File: rtl/interleaved_sram_ctrl.sv
// interleaved_sram_ctrl: valid/ready front end for a bank array of 1RW SRAM
// macros with bank decode, fixed-latency read tracking and a response FIFO.
//
// Ports:
//   clk0, rst_n        clock, async active-low reset
//   req_*              request channel (valid/ready, we, wmask, addr, wdata)
//   rsp_*              read response channel (valid/ready, rdata = FIFO head)
//   bank_csb           per-macro chip select, active low
//   bank_web/wmask/    broadcast write enable (active low), byte mask,
//   bank_addr/din      row address and write data
//   bank_dout          concatenated macro outputs, bank b at [b*DW +: DW]
module interleaved_sram_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int BANK_ADDR_BITS = 9,
  parameter int NUM_BANKS      = 4,
  parameter int INTERLEAVE     = 1,
  parameter int READ_LATENCY   = 2,
  parameter int RSP_FIFO_DEPTH = 4
) (
  input  logic                  clk0,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [DATA_WIDTH/8-1:0] req_wmask,
  input  logic [BANK_ADDR_BITS+$clog2(NUM_BANKS)-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [NUM_BANKS-1:0]  bank_csb,
  output logic                  bank_web,
  output logic [DATA_WIDTH/8-1:0] bank_wmask,
  output logic [BANK_ADDR_BITS-1:0] bank_addr,
  output logic [DATA_WIDTH-1:0] bank_din,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] bank_dout
);

  localparam int BSEL = $clog2(NUM_BANKS);
  localparam int AW   = BANK_ADDR_BITS + BSEL;
  localparam int BW   = (BSEL > 0) ? BSEL : 1;
  localparam int CW   = $clog2(RSP_FIFO_DEPTH + 1) + 1;
  localparam int PW   = (RSP_FIFO_DEPTH > 1) ?
                        $clog2(RSP_FIFO_DEPTH) : 1;

  logic [BW-1:0]             bank;
  logic [BANK_ADDR_BITS-1:0] row;
  logic                      fire;
  logic                      rd_fire;

  // Bank/row split of the flat word address.
  generate
    if (NUM_BANKS == 1) begin : g_one
      assign bank = '0;
      assign row  = req_addr;
    end else if (INTERLEAVE != 0) begin : g_ilv
      assign bank = req_addr[BSEL-1:0];
      assign row  = req_addr[AW-1:BSEL];
    end else begin : g_cont
      assign bank = req_addr[AW-1 -: BSEL];
      assign row  = req_addr[BANK_ADDR_BITS-1:0];
    end
  endgenerate

  logic [CW-1:0] fifo_count;
  logic [CW-1:0] inflight;

  // Every read in flight already owns a FIFO slot, so a push can
  // never find the FIFO full.
  assign req_ready = rst_n &
    ((fifo_count + inflight) < CW'(RSP_FIFO_DEPTH));
  assign fire    = req_valid & req_ready;
  assign rd_fire = fire & ~req_we;

  always_comb begin
    bank_csb = '1;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (fire && bank == BW'(b)) begin
        bank_csb[b] = 1'b0;
      end
    end
  end

  // Held inactive in reset so no macro sees a stray write.
  assign bank_web   = ~(req_we & rst_n);
  assign bank_addr  = row;
  assign bank_din   = req_wdata;
  assign bank_wmask = req_wmask;

  logic [READ_LATENCY-1:0] pipe_v;
  logic [BW-1:0]           pipe_b [READ_LATENCY];
  logic                    push;
  logic [BW-1:0]           push_bank;
  logic [DATA_WIDTH-1:0]   push_data;
  logic                    pop;

  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      pipe_v <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_b[i] <= '0;
      end
    end else begin
      pipe_v[0] <= rd_fire;
      pipe_b[0] <= bank;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_b[i] <= pipe_b[i-1];
      end
    end
  end

  assign push      = pipe_v[READ_LATENCY-1];
  assign push_bank = pipe_b[READ_LATENCY-1];

  always_comb begin
    push_data = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (push_bank == BW'(b)) begin
        push_data = bank_dout[b*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
    end else begin
      unique case ({rd_fire, push})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  logic [DATA_WIDTH-1:0] fifo_mem [RSP_FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;

  function automatic logic [PW-1:0] ptr_inc(
    input logic [PW-1:0] p
  );
    if (p == PW'(RSP_FIFO_DEPTH - 1)) begin
      return '0;
    end
    return p + PW'(1);
  endfunction

  assign rsp_valid = (fifo_count != '0);
  assign rsp_rdata = fifo_mem[rd_ptr];
  assign pop       = rsp_valid & rsp_ready;

  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < RSP_FIFO_DEPTH; i++) begin
        fifo_mem[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= push_data;
        wr_ptr           <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
    end
  end

  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      fifo_count <= '0;
    end else begin
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_interleaved_sram_ctrl.sv
// tb_interleaved_sram_ctrl: directed bench for interleaved_sram_ctrl with a
// behavioural 4-bank macro model (capture edge + output register).
module tb_interleaved_sram_ctrl;

  logic        clk0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [3:0]  req_wmask;
  logic [10:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [3:0]  bank_csb;
  logic        bank_web;
  logic [3:0]  bank_wmask;
  logic [8:0]  bank_addr;
  logic [31:0] bank_din;
  logic [127:0] bank_dout;

  logic        c_valid;
  logic        c_ready;
  logic [10:0] c_addr;
  logic        c_rsp_valid;
  logic [31:0] c_rdata;
  logic [3:0]  c_csb;
  logic        c_web;
  logic [3:0]  c_wmask;
  logic [8:0]  c_baddr;
  logic [31:0] c_din;

  int vectors = 0;
  int miscompares = 0;
  bit ovf_seen = 0;

  interleaved_sram_ctrl dut (
    .clk0(clk0), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_wmask(req_wmask),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .bank_csb(bank_csb),
    .bank_web(bank_web), .bank_wmask(bank_wmask),
    .bank_addr(bank_addr), .bank_din(bank_din),
    .bank_dout(bank_dout)
  );

  interleaved_sram_ctrl #(.INTERLEAVE(0)) dut_c (
    .clk0(clk0), .rst_n(rst_n),
    .req_valid(c_valid), .req_ready(c_ready),
    .req_we(1'b0), .req_wmask(4'hF),
    .req_addr(c_addr), .req_wdata(32'h0),
    .rsp_valid(c_rsp_valid), .rsp_ready(1'b1),
    .rsp_rdata(c_rdata), .bank_csb(c_csb),
    .bank_web(c_web), .bank_wmask(c_wmask),
    .bank_addr(c_baddr), .bank_din(c_din),
    .bank_dout(128'h0)
  );

  initial clk0 = 1'b0;
  always #5 clk0 = ~clk0;

  logic [31:0] mem [4][512];
  logic [31:0] rq  [4];
  logic [31:0] dq  [4];

  function automatic logic [31:0] merge(
    input logic [31:0] old, input logic [31:0] din,
    input logic [3:0] m
  );
    logic [31:0] w;
    w = old;
    for (int i = 0; i < 4; i++)
      if (m[i]) w[8*i +: 8] = din[8*i +: 8];
    return w;
  endfunction

  always @(posedge clk0) begin
    for (int b = 0; b < 4; b++) begin
      if (!bank_csb[b]) begin
        if (!bank_web)
          mem[b][bank_addr] <= merge(mem[b][bank_addr],
                                     bank_din, bank_wmask);
        else
          rq[b] <= mem[b][bank_addr];
      end
      dq[b] <= rq[b];
    end
  end

  assign bank_dout = {dq[3], dq[2], dq[1], dq[0]};

  always @(posedge clk0)
    if (rst_n && dut.push && !dut.pop && dut.fifo_count == 4)
      ovf_seen <= 1'b1;

  task automatic test_reset;
    @(negedge clk0);
    req_valid = 1'b1; req_we = 1'b1;
    #1;
    vectors++;
    if (req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_ready: got %b want 0", req_ready);
    end
    vectors++;
    if (bank_csb !== 4'hF || bank_web !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_bank: csb %b web %b want 1111 1",
               bank_csb, bank_web);
    end
    vectors++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL rst_rsp: valid %b data %h want 0 0",
               rsp_valid, rsp_rdata);
    end
    req_valid = 1'b0; req_we = 1'b0;
    @(negedge clk0);
    rst_n = 1'b1;
    #1;
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rel_ready: got %b want 1", req_ready);
    end
  endtask

  task automatic test_write_read;
    @(negedge clk0);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 11'd5;
    req_wdata = 32'hDEADBEEF; req_wmask = 4'hF;
    #1;
    vectors++;
    if (bank_csb !== 4'b1101 || bank_addr !== 9'd1 ||
        bank_web !== 1'b0 || bank_din !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL wr_drive: csb %b addr %h web %b din %h",
               bank_csb, bank_addr, bank_web, bank_din);
    end
    @(negedge clk0);
    req_we = 1'b0;
    #1;
    vectors++;
    if (bank_csb !== 4'b1101 || bank_web !== 1'b1) begin
      miscompares++;
      $display("FAIL rd_drive: csb %b web %b want 1101 1",
               bank_csb, bank_web);
    end
    @(negedge clk0);
    req_valid = 1'b0;
    @(negedge clk0);
    #1;
    vectors++;
    if (rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rd_early: rsp_valid %b want 0", rsp_valid);
    end
    @(negedge clk0);
    #1;
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL rd_data: valid %b data %h want 1 deadbeef",
               rsp_valid, rsp_rdata);
    end
    @(negedge clk0);
    #1;
    vectors++;
    if (rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rd_pop: rsp_valid %b want 0", rsp_valid);
    end
  endtask

  task automatic test_contiguous;
    logic [10:0] a [3];
    logic [3:0]  cs [3];
    logic [8:0]  r [3];
    a[0] = 11'h600; cs[0] = 4'b0111; r[0] = 9'h000;
    a[1] = 11'h2A5; cs[1] = 4'b1101; r[1] = 9'h0A5;
    a[2] = 11'h1FF; cs[2] = 4'b1110; r[2] = 9'h1FF;
    @(negedge clk0);
    c_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      c_addr = a[i];
      #1;
      vectors++;
      if (c_csb !== cs[i] || c_baddr !== r[i]) begin
        miscompares++;
        $display("FAIL contig_%0d: csb %b row %h want %b %h",
                 i, c_csb, c_baddr, cs[i], r[i]);
      end
    end
    @(negedge clk0);
    c_valid = 1'b0;
  endtask

  task automatic test_byte_mask;
    @(negedge clk0);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 11'd10;
    req_wdata = 32'h11223344; req_wmask = 4'hF;
    @(negedge clk0);
    req_wdata = 32'h000000AA; req_wmask = 4'b0001;
    @(negedge clk0);
    req_we = 1'b0;
    @(negedge clk0);
    req_valid = 1'b0;
    repeat (2) @(negedge clk0);
    #1;
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h112233AA) begin
      miscompares++;
      $display("FAIL byte_mask: valid %b data %h want 1 112233aa",
               rsp_valid, rsp_rdata);
    end
    @(negedge clk0);
  endtask

  task automatic test_backpressure;
    int acc;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk0);
      req_valid = 1'b1; req_we = 1'b1; req_wmask = 4'hF;
      req_addr = 11'(20 + i); req_wdata = 32'hA0000000 + i;
    end
    @(negedge clk0);
    req_valid = 1'b0; req_we = 1'b0;
    rsp_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk0);
      req_valid = 1'b1; req_addr = 11'(20 + acc);
      #1;
      if (req_ready) acc++;
    end
    @(negedge clk0);
    req_valid = 1'b0;
    #1;
    vectors++;
    if (acc != 4 || req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_accept: accepted %0d ready %b want 4 0",
               acc, req_ready);
    end
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hA0000000 + i) begin
        miscompares++;
        $display("FAIL bp_drain_%0d: valid %b data %h want 1 %h",
                 i, rsp_valid, rsp_rdata, 32'hA0000000 + i);
      end
      if (i < 2) begin
        vectors++;
        if (req_ready !== (i == 1)) begin
          miscompares++;
          $display("FAIL bp_ready_%0d: got %b want %b",
                   i, req_ready, (i == 1));
        end
      end
      @(negedge clk0);
    end
    #1;
    vectors++;
    if (rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_empty: rsp_valid %b want 0", rsp_valid);
    end
  endtask

  task automatic test_back_to_back;
    int issued;
    int got;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk0);
      req_valid = 1'b1; req_we = 1'b1; req_wmask = 4'hF;
      req_addr = 11'(40 + i); req_wdata = 32'hB0000000 + i;
    end
    @(negedge clk0);
    req_valid = 1'b0; req_we = 1'b0;
    rsp_ready = 1'b1;
    issued = 0; got = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk0);
      if (issued < 5) begin
        req_valid = 1'b1; req_addr = 11'(40 + issued);
      end else begin
        req_valid = 1'b0;
      end
      #1;
      if (issued < 5) begin
        vectors++;
        if (req_ready !== 1'b1 ||
            bank_csb !== ~(4'b0001 << ((40 + issued) % 4))) begin
          miscompares++;
          $display("FAIL b2b_issue_%0d: ready %b csb %b",
                   issued, req_ready, bank_csb);
        end
        issued++;
      end
      if (rsp_valid === 1'b1 && got < 5) begin
        vectors++;
        if (rsp_rdata !== 32'hB0000000 + got) begin
          miscompares++;
          $display("FAIL b2b_data_%0d: got %h want %h",
                   got, rsp_rdata, 32'hB0000000 + got);
        end
        got++;
      end
    end
    vectors++;
    if (got != 5) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d responses want 5", got);
    end
  endtask

  task automatic test_reset_inflight;
    int acc;
    @(negedge clk0);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 11'd20;
    @(negedge clk0);
    req_addr = 11'd21;
    @(negedge clk0);
    req_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk0);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      vectors++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL rst_flight_%0d: valid %b ready %b want 0 1",
                 c, rsp_valid, req_ready);
      end
      @(negedge clk0);
    end
    rsp_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      req_valid = 1'b1; req_addr = 11'(20 + acc);
      #1;
      if (req_ready) acc++;
      @(negedge clk0);
    end
    req_valid = 1'b0;
    vectors++;
    if (acc != 4) begin
      miscompares++;
      $display("FAIL rst_credit: accepted %0d want 4", acc);
    end
    rsp_ready = 1'b1;
    repeat (8) @(negedge clk0);
  endtask

  task automatic test_overflow_guard;
    vectors++;
    if (ovf_seen !== 1'b0) begin
      miscompares++;
      $display("FAIL fifo_overflow: seen %b want 0", ovf_seen);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_wmask = 4'h0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    c_valid = 1'b0; c_addr = '0;
    test_reset();
    test_write_read();
    test_contiguous();
    test_byte_mask();
    test_backpressure();
    test_back_to_back();
    test_reset_inflight();
    test_overflow_guard();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
